core_run_ctrl: RTL and testbench

- Run/debug sequencer for the 4-stage BatPU2 core.
- Owns the core's clk_en and sync_rst inputs and drives the power-on reset sequence, free run, halt, N-cycle single-step and one 10-bit instruction-address breakpoint.
- Sits between the host/debug command interface and the core; the core's inst_address is fed back for breakpoint compare.

---
 rtl/core_run_ctrl.sv | 175 +++++++++++++++++
 tb/tb_core_run_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
// Run/debug sequencer for the 4-stage BatPU2 core.
// Drives the core's clk_en and sync_rst: power-on reset sequence, free run,
// halt, N-cycle single-step and one instruction-address breakpoint.
// Every output comes straight from a flop, so the core sees glitch-free
// control lines and async_rst forces the reset values immediately.
module core_run_ctrl #(
  parameter int RST_CYCLES = 4,
  parameter int AUTO_RUN   = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             async_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_arg,
  input  logic             bp_en,
  input  logic [9:0]       bp_addr,
  input  logic [9:0]       inst_address,
  output logic             core_clk_en,
  output logic             core_sync_rst,
  output logic [1:0]       run_state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_HALTED = 2'd1,
    ST_RUN    = 2'd2,
    ST_STEP   = 2'd3
  } state_e;

  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_HALT  = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_RESET = 2'd3;

  localparam int             RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

  state_e             state_q, state_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [7:0]         step_cnt_q, step_cnt_d;
  logic               bp_skip_q, bp_skip_d;
  logic               bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic               clk_en_q, sync_rst_q, ready_q;

  logic cmd_acc;
  logic bp_match;

  assign cmd_acc  = cmd_valid && ready_q;
  // Resuming from HALTED sets bp_skip so the instruction we stopped on can
  // execute once without immediately re-hitting the breakpoint.
  assign bp_match = bp_en && !bp_skip_q && (inst_address == bp_addr);

  // Next-state, counter and flag logic.
  always_comb begin
    // NOTE: every signal driven here gets a default first, otherwise any path
    // that skips an assignment would infer a latch.
    state_d       = state_q;
    rst_cnt_d     = '0;
    step_cnt_d    = step_cnt_q;
    bp_skip_d     = bp_skip_q;
    bp_hit_d      = bp_hit_q;
    cycle_count_d = cycle_count_q;

    // Enabled, non-reset core cycle: the core advances on this edge.
    if (state_q == ST_RUN || state_q == ST_STEP) begin
      cycle_count_d = cycle_count_q + 1'b1;
      bp_skip_d     = 1'b0;
    end

    unique case (state_q)
      ST_RESET: begin
        rst_cnt_d = rst_cnt_q + 1'b1;
        if (rst_cnt_q == RST_LAST) begin
          rst_cnt_d = '0;
          state_d   = (AUTO_RUN != 0) ? ST_RUN : ST_HALTED;
        end
      end

      ST_HALTED: begin
        if (cmd_acc) begin
          unique case (cmd_op)
            OP_RUN: begin
              state_d   = ST_RUN;
              bp_hit_d  = 1'b0;
              bp_skip_d = 1'b1;
            end
            OP_STEP: begin
              state_d    = ST_STEP;
              step_cnt_d = (cmd_arg == 8'd0) ? 8'd1 : cmd_arg;
              bp_hit_d   = 1'b0;
              bp_skip_d  = 1'b1;
            end
            OP_RESET: begin
              state_d       = ST_RESET;
              bp_hit_d      = 1'b0;
              cycle_count_d = '0;
            end
            OP_HALT: ;
          endcase
        end
      end

      ST_RUN: begin
        // RESET command beats the breakpoint, which beats HALT.
        if (cmd_acc && cmd_op == OP_RESET) begin
          state_d       = ST_RESET;
          bp_hit_d      = 1'b0;
          cycle_count_d = '0;
        end else if (bp_match) begin
          state_d  = ST_HALTED;
          bp_hit_d = 1'b1;
        end else if (cmd_acc && cmd_op == OP_HALT) begin
          state_d = ST_HALTED;
        end
      end

      ST_STEP: begin
        step_cnt_d = step_cnt_q - 8'd1;
        if (bp_match) begin
          state_d  = ST_HALTED;
          bp_hit_d = 1'b1;
        end else if (step_cnt_q == 8'd1) begin
          state_d = ST_HALTED;
        end
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q       <= ST_RESET;
      rst_cnt_q     <= '0;
      step_cnt_q    <= '0;
      bp_skip_q     <= 1'b0;
      bp_hit_q      <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values; blocking here would let later lines see already-updated state.
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      step_cnt_q    <= step_cnt_d;
      bp_skip_q     <= bp_skip_d;
      bp_hit_q      <= bp_hit_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // Core control outputs registered from the next state.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      clk_en_q   <= 1'b1;
      sync_rst_q <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      clk_en_q   <= (state_d != ST_HALTED);
      sync_rst_q <= (state_d == ST_RESET);
      ready_q    <= (state_d == ST_HALTED) || (state_d == ST_RUN);
    end
  end

  assign core_clk_en   = clk_en_q;
  assign core_sync_rst = sync_rst_q;
  assign cmd_ready     = ready_q;
  assign run_state     = state_q;
  assign bp_hit        = bp_hit_q;
  assign cycle_count   = cycle_count_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: two instances (default parameters, and a short
// reset / auto-run / 4-bit counter variant) share one stimulus stream and
// are compared every cycle against a behavioural model, plus directed checks.
module tb_core_run_ctrl;

  logic       clk;
  logic       async_rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       bp_en;
  logic [9:0] bp_addr;
  logic [9:0] inst_address;

  logic        a_cmd_ready, a_core_clk_en, a_core_sync_rst, a_bp_hit;
  logic [1:0]  a_run_state;
  logic [31:0] a_cycle_count;
  logic        b_cmd_ready, b_core_clk_en, b_core_sync_rst, b_bp_hit;
  logic [1:0]  b_run_state;
  logic [3:0]  b_cycle_count;

  int checks   = 0;
  int failures = 0;

  core_run_ctrl dut_a (
    .clk(clk), .async_rst(async_rst),
    .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .bp_en(bp_en), .bp_addr(bp_addr), .inst_address(inst_address),
    .core_clk_en(a_core_clk_en), .core_sync_rst(a_core_sync_rst),
    .run_state(a_run_state), .bp_hit(a_bp_hit), .cycle_count(a_cycle_count)
  );

  core_run_ctrl #(.RST_CYCLES(2), .AUTO_RUN(1), .CNT_W(4)) dut_b (
    .clk(clk), .async_rst(async_rst),
    .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .bp_en(bp_en), .bp_addr(bp_addr), .inst_address(inst_address),
    .core_clk_en(b_core_clk_en), .core_sync_rst(b_core_sync_rst),
    .run_state(b_run_state), .bp_hit(b_bp_hit), .cycle_count(b_cycle_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural model ----------------
  localparam int M_RESET = 0, M_HALTED = 1, M_RUN = 2, M_STEP = 3;

  typedef struct {
    int              mode;        // observable run_state
    int              rst_seen;    // reset cycles already spent
    int              steps_left;  // enabled cycles still owed to a STEP
    bit              skip;        // breakpoint suppressed for this cycle
    bit              hit;
    longint unsigned count;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = M_RESET; m.rst_seen = 0; m.steps_left = 0;
    m.skip = 1'b0; m.hit = 1'b0; m.count = 0;
    return m;
  endfunction

  function automatic mdl_t enter_reset(mdl_t m);
    mdl_t n = m;
    n.mode = M_RESET; n.rst_seen = 0; n.count = 0; n.hit = 1'b0;
    return n;
  endfunction

  // One clock edge of the rules, using the inputs present at that edge.
  function automatic mdl_t mdl_step(mdl_t m, int rst_cycles, bit auto_run, int cnt_w);
    mdl_t n = m;
    longint unsigned modulus = 64'd1 << cnt_w;
    bit accepted = cmd_valid && (m.mode == M_HALTED || m.mode == M_RUN);
    bit bp       = bp_en && !m.skip && (inst_address == bp_addr);
    if (m.mode == M_RUN || m.mode == M_STEP) begin
      n.count = (m.count + 1) % modulus;
      n.skip  = 1'b0;
    end
    case (m.mode)
      M_RESET: begin
        n.rst_seen = m.rst_seen + 1;
        if (n.rst_seen == rst_cycles) begin
          n.mode = auto_run ? M_RUN : M_HALTED;
          n.rst_seen = 0;
        end
      end
      M_HALTED: if (accepted) begin
        if (cmd_op == 2'd0) begin
          n.mode = M_RUN; n.hit = 1'b0; n.skip = 1'b1;
        end else if (cmd_op == 2'd2) begin
          n.mode = M_STEP; n.hit = 1'b0; n.skip = 1'b1;
          n.steps_left = (cmd_arg == 8'd0) ? 1 : int'(cmd_arg);
        end else if (cmd_op == 2'd3) begin
          n = enter_reset(n);
        end
      end
      M_RUN: begin
        if (accepted && cmd_op == 2'd3) n = enter_reset(n);
        else if (bp) begin n.mode = M_HALTED; n.hit = 1'b1; end
        else if (accepted && cmd_op == 2'd1) n.mode = M_HALTED;
      end
      default: begin
        if (bp) begin n.mode = M_HALTED; n.hit = 1'b1; end
        else if (m.steps_left == 1) n.mode = M_HALTED;
        else n.steps_left = m.steps_left - 1;
      end
    endcase
    return n;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("a.run_state", a_run_state, ma.mode);
    check("a.clk_en", a_core_clk_en, ma.mode != M_HALTED);
    check("a.sync_rst", a_core_sync_rst, ma.mode == M_RESET);
    check("a.cmd_ready", a_cmd_ready, ma.mode == M_HALTED || ma.mode == M_RUN);
    check("a.bp_hit", a_bp_hit, ma.hit);
    check("a.cycle_count", a_cycle_count, ma.count);
    check("b.run_state", b_run_state, mb.mode);
    check("b.clk_en", b_core_clk_en, mb.mode != M_HALTED);
    check("b.sync_rst", b_core_sync_rst, mb.mode == M_RESET);
    check("b.cmd_ready", b_cmd_ready, mb.mode == M_HALTED || mb.mode == M_RUN);
    check("b.bp_hit", b_bp_hit, mb.hit);
    check("b.cycle_count", b_cycle_count, mb.count);
  endtask

  // Advance one clock, update the models, compare 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (async_rst) begin
      ma = mdl_reset();
      mb = mdl_reset();
    end else begin
      ma = mdl_step(ma, 4, 1'b0, 32);
      mb = mdl_step(mb, 2, 1'b1, 4);
    end
    #1;
    compare_all();
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Count dut_a enabled cycles (and how many of them had cmd_ready) over a window.
  task automatic count_enabled(input int window, output int en, output int rdy);
    en  = 0;
    rdy = 0;
    for (int i = 0; i < window; i++) begin
      if (a_core_clk_en) begin
        en++;
        if (a_cmd_ready) rdy++;
      end
      tick();
    end
  endtask

  // Count dut_a cycles spent with core_sync_rst high, bounded.
  task automatic count_reset(output int n);
    n = 0;
    for (int i = 0; i < 20 && a_core_sync_rst; i++) begin
      if (a_core_clk_en) n++;
      tick();
    end
  endtask

  int n_en, n_rdy, n_rst;

  initial begin
    async_rst    = 1'b1;
    cmd_valid    = 1'b0;
    cmd_op       = 2'd0;
    cmd_arg      = 8'd0;
    bp_en        = 1'b0;
    bp_addr      = 10'h000;
    inst_address = 10'h000;
    ma = mdl_reset();
    mb = mdl_reset();

    // Reset values while async_rst is held.
    #3;
    compare_all();
    tick();
    tick();
    async_rst = 1'b0;

    // Power-on sequence: 4 cycles of sync_rst with clk_en, then HALTED.
    count_reset(n_rst);
    check("rst_cycles", n_rst, 4);
    check("post_rst.state", a_run_state, 2'd1);
    check("post_rst.clk_en", a_core_clk_en, 1'b0);
    check("post_rst.ready", a_cmd_ready, 1'b1);
    check("post_rst.count", a_cycle_count, 0);

    // STEP 3 -> exactly 3 enabled cycles, cmd_ready low throughout.
    send_cmd(2'd2, 8'd3);
    count_enabled(8, n_en, n_rdy);
    check("step3.enabled", n_en, 3);
    check("step3.ready_during", n_rdy, 0);
    check("step3.state", a_run_state, 2'd1);
    check("step3.count", a_cycle_count, 3);

    // STEP 0 is treated as one cycle.
    send_cmd(2'd2, 8'd0);
    count_enabled(8, n_en, n_rdy);
    check("step0.enabled", n_en, 1);
    check("step0.count", a_cycle_count, 4);

    // Breakpoint at 0x012 while running.
    bp_en   = 1'b1;
    bp_addr = 10'h012;
    send_cmd(2'd0, 8'd0);
    inst_address = 10'h010; tick();
    inst_address = 10'h011; tick();
    check("bp.pre_state", a_run_state, 2'd2);
    inst_address = 10'h012; tick();
    check("bp.state", a_run_state, 2'd1);
    check("bp.clk_en", a_core_clk_en, 1'b0);
    check("bp.hit", a_bp_hit, 1'b1);
    check("bp.count", a_cycle_count, 7);

    // Resume from the breakpoint address: no immediate retrigger.
    send_cmd(2'd0, 8'd0);
    check("resume.hit", a_bp_hit, 1'b0);
    check("resume.clk_en", a_core_clk_en, 1'b1);
    tick();
    check("resume.no_retrigger", a_run_state, 2'd2);
    inst_address = 10'h013; tick();

    // HALT and breakpoint in the same cycle.
    inst_address = 10'h012;
    send_cmd(2'd1, 8'd0);
    check("halt_bp.state", a_run_state, 2'd1);
    check("halt_bp.hit", a_bp_hit, 1'b1);

    // RESET and breakpoint in the same cycle: RESET wins.
    inst_address = 10'h013;
    send_cmd(2'd0, 8'd0);
    tick();
    inst_address = 10'h012;
    send_cmd(2'd3, 8'd0);
    check("rst_bp.state", a_run_state, 2'd0);
    check("rst_bp.hit", a_bp_hit, 1'b0);
    check("rst_bp.count", a_cycle_count, 0);
    inst_address = 10'h000;
    repeat (4) tick();
    check("rst_bp.after", a_run_state, 2'd1);

    // 4-bit counter wrap on dut_b (auto-run after 2 reset cycles).
    bp_en     = 1'b0;
    async_rst = 1'b1;
    tick();
    async_rst = 1'b0;
    repeat (2) tick();
    check("wrap.running", b_run_state, 2'd2);
    repeat (16) tick();
    send_cmd(2'd1, 8'd0);
    check("wrap.count", b_cycle_count, 4'd1);
    check("wrap.state", b_run_state, 2'd1);
    repeat (5) tick();
    check("wrap.hold", b_cycle_count, 4'd1);

    // async_rst mid-STEP with 5 steps still pending.
    send_cmd(2'd2, 8'd7);
    tick();
    tick();
    check("mid_step.state", a_run_state, 2'd3);
    #2 async_rst = 1'b1;
    #1;
    check("async.state", a_run_state, 2'd0);
    check("async.sync_rst", a_core_sync_rst, 1'b1);
    check("async.clk_en", a_core_clk_en, 1'b1);
    check("async.ready", a_cmd_ready, 1'b0);
    check("async.count", a_cycle_count, 0);
    ma = mdl_reset();
    mb = mdl_reset();
    compare_all();
    #1 async_rst = 1'b0;
    count_reset(n_rst);
    check("async.rst_cycles", n_rst, 4);
    count_enabled(8, n_en, n_rdy);
    check("async.no_residual", n_en, 0);
    check("async.final_count", a_cycle_count, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      cmd_valid    = ($urandom_range(0, 2) == 0);
      cmd_op       = 2'($urandom_range(0, 3));
      cmd_arg      = 8'($urandom_range(0, 6));
      bp_en        = ($urandom_range(0, 3) != 0);
      bp_addr      = 10'h012;
      inst_address = 10'h011 + 10'($urandom_range(0, 2));
      async_rst    = ($urandom_range(0, 99) == 0);
      tick();
      async_rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
